// File: rtl/order_pkg.sv
// Shared definitions for the order arbiter: FSM state codes and the default price width.
package order_pkg;

  localparam int unsigned PRICE_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: returns the first requesting index after ptr,
// wrapping modulo N_SRC.
module rr_priority_pick #(
  parameter int unsigned N_SRC = 4
) (
  input  logic [N_SRC-1:0]         req,
  input  logic [$clog2(N_SRC)-1:0] ptr,
  output logic [$clog2(N_SRC)-1:0] gnt_idx,
  output logic                     any_req
);

  localparam int unsigned IDX_W = $clog2(N_SRC);

  logic [N_SRC-1:0] rot;
  logic [31:0]      base;
  logic [31:0]      off;
  logic             found;

  // Rotate so the slot after ptr sits at bit 0, take the lowest set bit, map back.
  always_comb begin
    base  = (32'(ptr) + 32'd1) % N_SRC;
    rot   = '0;
    off   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      rot[k] = req[IDX_W'((base + k) % N_SRC)];
    end
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (rot[k] && !found) begin
        off   = k;
        found = 1'b1;
      end
    end
    any_req = found;
    gnt_idx = IDX_W'((base + off) % N_SRC);
  end

endmodule

// File: rtl/order_arbiter.sv
// Round-robin scheduler sharing one matching engine between N_SRC order sources;
// issues one order, waits MATCH_LAT cycles and attributes any match to its source.
module order_arbiter
  import order_pkg::*;
#(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned PRICE_W   = PRICE_W_DEF,
  parameter int unsigned MATCH_LAT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC*PRICE_W-1:0]   src_buy,
  input  logic [N_SRC*PRICE_W-1:0]   src_sell,
  output logic [N_SRC-1:0]           src_ready,
  input  logic                       halt_flag,
  input  logic                       match_flag,
  output logic                       order_valid,
  output logic [PRICE_W-1:0]         buy_price,
  output logic [PRICE_W-1:0]         sell_price,
  output logic                       match_pulse,
  output logic [$clog2(N_SRC)-1:0]   match_src,
  output logic [1:0]                 state
);

  localparam int unsigned IDX_W = $clog2(N_SRC);
  localparam int unsigned CNT_W = (MATCH_LAT > 1) ? $clog2(MATCH_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MATCH_LAT - 1);
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N_SRC - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   cur_src_q, cur_src_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               halt_seen_q, halt_seen_d;
  logic               match_seen_q, match_seen_d;
  logic               order_valid_d;
  logic               match_pulse_d;
  logic [IDX_W-1:0]   match_src_d;
  logic [PRICE_W-1:0] buy_d, sell_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [PRICE_W-1:0] buy_arr  [N_SRC];
  logic [PRICE_W-1:0] sell_arr [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign buy_arr[i]  = src_buy[i*PRICE_W +: PRICE_W];
    assign sell_arr[i] = src_sell[i*PRICE_W +: PRICE_W];
  end

  rr_priority_pick #(
    .N_SRC (N_SRC)
  ) u_pick (
    .req     (src_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any_req (pick_any)
  );

  // Next-state, grant and datapath decisions.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cur_src_d     = cur_src_q;
    cnt_d         = cnt_q;
    halt_seen_d   = halt_seen_q;
    match_seen_d  = match_seen_q;
    order_valid_d = 1'b0;
    match_pulse_d = 1'b0;
    match_src_d   = match_src;
    buy_d         = buy_price;
    sell_d        = sell_price;
    src_ready     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (halt_flag) begin
          state_d = ST_HALT;
        end else if (pick_any && !reset) begin
          src_ready[pick_idx] = 1'b1;
          buy_d               = buy_arr[pick_idx];
          sell_d              = sell_arr[pick_idx];
          order_valid_d       = 1'b1;
          rr_ptr_d            = pick_idx;
          cur_src_d           = pick_idx;
          state_d             = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d        = CNT_LOAD;
        halt_seen_d  = halt_flag;
        match_seen_d = 1'b0;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (halt_flag) begin
          halt_seen_d = 1'b1;
        end
        // Only the first match in the window is attributed.
        if (match_flag && !match_seen_q) begin
          match_pulse_d = 1'b1;
          match_src_d   = cur_src_q;
          match_seen_d  = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = (halt_flag || halt_seen_q) ? ST_HALT : ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HALT: begin
        if (!halt_flag) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= PTR_RESET;
      cur_src_q    <= '0;
      cnt_q        <= '0;
      halt_seen_q  <= 1'b0;
      match_seen_q <= 1'b0;
      order_valid  <= 1'b0;
      match_pulse  <= 1'b0;
      match_src    <= '0;
      buy_price    <= '0;
      sell_price   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cur_src_q    <= cur_src_d;
      cnt_q        <= cnt_d;
      halt_seen_q  <= halt_seen_d;
      match_seen_q <= match_seen_d;
      order_valid  <= order_valid_d;
      match_pulse  <= match_pulse_d;
      match_src    <= match_src_d;
      buy_price    <= buy_d;
      sell_price   <= sell_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_order_arbiter.sv
// Self-checking bench for order_arbiter: directed vector table, rotation and
// reset corner sequences, then randomized traffic against a reference model.
module tb_order_arbiter;

  localparam int unsigned N_SRC     = 4;
  localparam int unsigned PRICE_W   = 8;
  localparam int unsigned MATCH_LAT = 2;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned N_ROWS    = 25;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [N_SRC-1:0]         src_valid;
  logic [N_SRC*PRICE_W-1:0] src_buy;
  logic [N_SRC*PRICE_W-1:0] src_sell;
  logic [N_SRC-1:0]         src_ready;
  logic                     halt_flag;
  logic                     match_flag;
  logic                     order_valid;
  logic [PRICE_W-1:0]       buy_price;
  logic [PRICE_W-1:0]       sell_price;
  logic                     match_pulse;
  logic [IDX_W-1:0]         match_src;
  logic [1:0]               state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  order_arbiter #(
    .N_SRC     (N_SRC),
    .PRICE_W   (PRICE_W),
    .MATCH_LAT (MATCH_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .src_valid   (src_valid),
    .src_buy     (src_buy),
    .src_sell    (src_sell),
    .src_ready   (src_ready),
    .halt_flag   (halt_flag),
    .match_flag  (match_flag),
    .order_valid (order_valid),
    .buy_price   (buy_price),
    .sell_price  (sell_price),
    .match_pulse (match_pulse),
    .match_src   (match_src),
    .state       (state)
  );

  typedef struct {
    logic [3:0] valid;
    logic       halt;
    logic       match;
    logic [3:0] ready;
    logic       ov;
    logic [7:0] buy;
    logic [7:0] sell;
    logic [1:0] st;
    logic       pulse;
    logic [1:0] msrc;
  } vec_t;

  vec_t tbl [N_ROWS];

  // Reference model: slot age since grant, halt bookkeeping, rotation pointer.
  int         m_ptr, m_age, m_owner, m_msrc;
  bit         m_halted, m_hpend, m_matched, m_pulse;
  logic [7:0] m_buy, m_sell;

  bit         pend  [N_SRC];
  logic [7:0] pbuy  [N_SRC];
  logic [7:0] psell [N_SRC];
  int         halt_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] er, input logic eov,
                           input logic [7:0] eb, input logic [7:0] es, input logic [1:0] est,
                           input logic ep, input logic [1:0] em);
    chk({tag, "_ready"}, 32'(src_ready), 32'(er));
    chk({tag, "_order_valid"}, 32'(order_valid), 32'(eov));
    chk({tag, "_buy"}, 32'(buy_price), 32'(eb));
    chk({tag, "_sell"}, 32'(sell_price), 32'(es));
    chk({tag, "_state"}, 32'(state), 32'(est));
    chk({tag, "_pulse"}, 32'(match_pulse), 32'(ep));
    chk({tag, "_msrc"}, 32'(match_src), 32'(em));
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic h, input logic m,
                              input logic [3:0] r, input logic ov, input logic [7:0] b,
                              input logic [7:0] s, input logic [1:0] st, input logic p,
                              input logic [1:0] ms);
    vec_t t;
    t.valid = v; t.halt = h; t.match = m; t.ready = r; t.ov = ov;
    t.buy = b; t.sell = s; t.st = st; t.pulse = p; t.msrc = ms;
    return t;
  endfunction

  function automatic int pick(input logic [N_SRC-1:0] v, input int ptr);
    for (int i = 1; i <= int'(N_SRC); i++) begin
      if (v[2'((ptr + i) % int'(N_SRC))]) return (ptr + i) % int'(N_SRC);
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = N_SRC - 1; m_age = 0; m_owner = 0; m_msrc = 0;
    m_halted = 0; m_hpend = 0; m_matched = 0; m_pulse = 0;
    m_buy = '0; m_sell = '0;
  endtask

  task automatic model_check();
    int g;
    logic [3:0] er;
    logic [1:0] est;
    er = '0;
    g = (m_age == 0 && !m_halted && !halt_flag) ? pick(src_valid, m_ptr) : -1;
    if (g >= 0) er[g] = 1'b1;
    if (m_halted)        est = 2'd3;
    else if (m_age == 0) est = 2'd0;
    else if (m_age == 1) est = 2'd1;
    else                 est = 2'd2;
    check_all("rnd", er, (m_age == 1), m_buy, m_sell, est, m_pulse, 2'(m_msrc));
  endtask

  task automatic model_step();
    int g;
    m_pulse = 0;
    if (m_age == 0) begin
      if (m_halted) begin
        if (!halt_flag) m_halted = 0;
      end else if (halt_flag) begin
        m_halted = 1;
      end else begin
        g = pick(src_valid, m_ptr);
        if (g >= 0) begin
          m_ptr = g; m_owner = g; m_age = 1; m_matched = 0; m_hpend = 0;
          m_buy  = src_buy[g*PRICE_W +: PRICE_W];
          m_sell = src_sell[g*PRICE_W +: PRICE_W];
        end
      end
    end else begin
      if (m_age >= 2 && match_flag && !m_matched) begin
        m_pulse = 1; m_msrc = m_owner; m_matched = 1;
      end
      if (halt_flag) m_hpend = 1;
      if (m_age == int'(MATCH_LAT) + 1) begin
        m_age = 0; m_halted = m_hpend;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic set_fixed_prices();
    for (int i = 0; i < int'(N_SRC); i++) begin
      src_buy[i*PRICE_W +: PRICE_W]  = 8'(8'h30 + 8'h10 * i);
      src_sell[i*PRICE_W +: PRICE_W] = 8'(8'h2C + 8'h10 * i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; src_valid = '0; halt_flag = 1'b0; match_flag = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset", 4'b0000, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 2'd0);
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_random();
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (!pend[i] && $urandom_range(0, 2) == 0) begin
        pend[i] = 1'b1; pbuy[i] = 8'($urandom); psell[i] = 8'($urandom);
      end
      src_valid[i] = pend[i];
      src_buy[i*PRICE_W +: PRICE_W]  = pbuy[i];
      src_sell[i*PRICE_W +: PRICE_W] = psell[i];
    end
    if (halt_cnt > 0) halt_cnt--;
    else if ($urandom_range(0, 39) == 0) halt_cnt = int'($urandom_range(1, 8));
    halt_flag  = (halt_cnt > 0);
    match_flag = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gi[$];
    int gc[$];
    int idx;

    src_buy = '0; src_sell = '0;
    tbl[0]  = mk(4'b0010, 0, 0, 4'b0010, 0, 8'h00, 8'h00, 2'd0, 0, 2'd0);
    tbl[1]  = mk(4'b0000, 0, 0, 4'b0000, 1, 8'h40, 8'h3C, 2'd1, 0, 2'd0);
    tbl[2]  = mk(4'b0100, 0, 1, 4'b0000, 0, 8'h40, 8'h3C, 2'd2, 0, 2'd0);
    tbl[3]  = mk(4'b0100, 0, 0, 4'b0000, 0, 8'h40, 8'h3C, 2'd2, 1, 2'd1);
    tbl[4]  = mk(4'b0100, 0, 0, 4'b0100, 0, 8'h40, 8'h3C, 2'd0, 0, 2'd1);
    tbl[5]  = mk(4'b0000, 0, 0, 4'b0000, 1, 8'h50, 8'h4C, 2'd1, 0, 2'd1);
    tbl[6]  = mk(4'b0000, 0, 0, 4'b0000, 0, 8'h50, 8'h4C, 2'd2, 0, 2'd1);
    tbl[7]  = mk(4'b0000, 0, 1, 4'b0000, 0, 8'h50, 8'h4C, 2'd2, 0, 2'd1);
    tbl[8]  = mk(4'b0000, 0, 1, 4'b0000, 0, 8'h50, 8'h4C, 2'd0, 1, 2'd2);
    tbl[9]  = mk(4'b0000, 0, 1, 4'b0000, 0, 8'h50, 8'h4C, 2'd0, 0, 2'd2);
    tbl[10] = mk(4'b1001, 0, 0, 4'b1000, 0, 8'h50, 8'h4C, 2'd0, 0, 2'd2);
    tbl[11] = mk(4'b0001, 0, 0, 4'b0000, 1, 8'h60, 8'h5C, 2'd1, 0, 2'd2);
    tbl[12] = mk(4'b0001, 1, 0, 4'b0000, 0, 8'h60, 8'h5C, 2'd2, 0, 2'd2);
    tbl[13] = mk(4'b0001, 1, 0, 4'b0000, 0, 8'h60, 8'h5C, 2'd2, 0, 2'd2);
    tbl[14] = mk(4'b0001, 1, 0, 4'b0000, 0, 8'h60, 8'h5C, 2'd3, 0, 2'd2);
    tbl[15] = mk(4'b0001, 1, 0, 4'b0000, 0, 8'h60, 8'h5C, 2'd3, 0, 2'd2);
    tbl[16] = mk(4'b0001, 0, 0, 4'b0000, 0, 8'h60, 8'h5C, 2'd3, 0, 2'd2);
    tbl[17] = mk(4'b0001, 0, 0, 4'b0001, 0, 8'h60, 8'h5C, 2'd0, 0, 2'd2);
    tbl[18] = mk(4'b0000, 0, 0, 4'b0000, 1, 8'h30, 8'h2C, 2'd1, 0, 2'd2);
    tbl[19] = mk(4'b0000, 0, 0, 4'b0000, 0, 8'h30, 8'h2C, 2'd2, 0, 2'd2);
    tbl[20] = mk(4'b0000, 0, 0, 4'b0000, 0, 8'h30, 8'h2C, 2'd2, 0, 2'd2);
    tbl[21] = mk(4'b0001, 1, 0, 4'b0000, 0, 8'h30, 8'h2C, 2'd0, 0, 2'd2);
    tbl[22] = mk(4'b0001, 0, 0, 4'b0000, 0, 8'h30, 8'h2C, 2'd3, 0, 2'd2);
    tbl[23] = mk(4'b0001, 0, 0, 4'b0001, 0, 8'h30, 8'h2C, 2'd0, 0, 2'd2);
    tbl[24] = mk(4'b0000, 0, 0, 4'b0000, 1, 8'h30, 8'h2C, 2'd1, 0, 2'd2);

    // Directed vector table: single-source grant, match attribution, halt handling.
    do_reset();
    set_fixed_prices();
    for (int r = 0; r < int'(N_ROWS); r++) begin
      src_valid  = tbl[r].valid;
      halt_flag  = tbl[r].halt;
      match_flag = tbl[r].match;
      @(negedge clk);
      check_all($sformatf("row%0d", r), tbl[r].ready, tbl[r].ov, tbl[r].buy, tbl[r].sell,
                tbl[r].st, tbl[r].pulse, tbl[r].msrc);
      tick();
    end

    // All sources requesting continuously: strict rotation with fixed spacing.
    do_reset();
    set_fixed_prices();
    src_valid = 4'b1111;
    for (int c = 0; c < 40 && gi.size() < 5; c++) begin
      @(negedge clk);
      if (src_ready != '0) begin
        chk("rot_onehot", 32'($countones(src_ready)), 32'd1);
        idx = 0;
        for (int i = 0; i < int'(N_SRC); i++) if (src_ready[i]) idx = i;
        gi.push_back(idx);
        gc.push_back(c);
      end
      tick();
    end
    chk("rot_count", 32'(gi.size()), 32'd5);
    for (int k = 0; k < gi.size(); k++) begin
      chk($sformatf("rot_idx%0d", k), 32'(gi[k]), 32'(k % int'(N_SRC)));
      if (k > 0) chk($sformatf("rot_gap%0d", k), 32'(gc[k] - gc[k-1]), 32'(MATCH_LAT + 2));
    end

    // Reset in WAIT with match_flag high: order dropped, no pulse, source 0 first after.
    do_reset();
    set_fixed_prices();
    src_valid = 4'b0100;
    @(negedge clk);
    chk("rw_grant", 32'(src_ready), 32'h4);
    tick();
    src_valid = 4'b0000;
    @(negedge clk);
    chk("rw_issue", 32'(state), 32'd1);
    tick();
    match_flag = 1'b1;
    @(negedge clk);
    chk("rw_wait", 32'(state), 32'd2);
    #2;
    reset = 1'b1;
    src_valid = 4'b1111;
    #1;
    check_all("rw_in_reset", 4'b0000, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 2'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_all("rw_after", 4'b0001, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 2'd0);
    tick();
    src_valid = 4'b1110;
    match_flag = 1'b0;
    @(negedge clk);
    check_all("rw_issue0", 4'b0000, 1'b1, 8'h30, 8'h2C, 2'd1, 1'b0, 2'd0);
    tick();

    // Randomized traffic against the reference model.
    do_reset();
    halt_cnt = 0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      pend[i] = 1'b0; pbuy[i] = '0; psell[i] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      @(negedge clk);
      model_check();
      model_step();
      for (int i = 0; i < int'(N_SRC); i++) begin
        if (src_ready[i] && src_valid[i]) pend[i] = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
